// File: rtl/mesh_db_sort.sv
// Purpose : SQRT_N x SQRT_N mesh of PEs that shearsorts built-in packets by address, in snake order.
// Latency : pending drops max(T, SORT_CYCLES) cycles after reset release, where T=(2*log2(SQRT_N)+1)*SQRT_N.
// Backpr. : none; the block is self-stimulating, with no handshake and no inputs besides clk/rst.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst           synchronous active-high reset; reloads the packets and restarts the schedule
//   nanci_result  element i = {pending, addr, data} of the PE at snake rank i
module mesh_db_sort #(
  parameter int N           = 64,
  parameter int SQRT_N      = 8,
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 6,
  parameter int SORT_CYCLES = 53
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [ADDR_WIDTH+DATA_WIDTH:0]   nanci_result [0:N-1]
);

  localparam int W    = ADDR_WIDTH + DATA_WIDTH;
  localparam int L    = $clog2(SQRT_N);
  localparam int T    = (2 * L + 1) * SQRT_N;
  localparam int MAXC = (T > SORT_CYCLES) ? T : SORT_CYCLES;
  localparam int SW   = $clog2(T + 1);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [SW-1:0] T_S   = SW'(T);
  localparam logic [CW-1:0] MAX_C = CW'(MAXC);
  localparam logic [CW-1:0] SC_C  = CW'(SORT_CYCLES);

  // Snake rank of the PE at row r, grid column c.
  function automatic int rank_of(input int r, input int c);
    return r * SQRT_N + (((r % 2) == 0) ? c : (SQRT_N - 1 - c));
  endfunction

  logic [SW-1:0]       step_q, step_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic                done_q, done_d;
  logic [N-1:0][W-1:0] pkt_q, pkt_d, init_pkt;

  logic sort_en;
  logic col_phase;
  logic par;

  // Phases are SQRT_N (a power of two) steps long, so the phase parity is
  // step bit L and the in-phase step parity is step bit 0.
  assign sort_en   = (step_q != T_S);
  assign col_phase = step_q[L];
  assign par       = step_q[0];

  always_comb begin
    step_d = sort_en ? (step_q + 1'b1) : step_q;
    cyc_d  = (cyc_q != MAX_C) ? (cyc_q + 1'b1) : cyc_q;
    done_d = done_q | ((step_d == T_S) && (cyc_d >= SC_C));
  end

  for (genvar k = 0; k < N; k++) begin : g_pe
    localparam int R   = k / SQRT_N;
    localparam int J   = k % SQRT_N;
    localparam int COL = ((R % 2) == 0) ? J : (SQRT_N - 1 - J);

    // Within a row, rank order is already the sort order for both row
    // directions, and with an even row width the column-index pairing of
    // odd-even transposition lands on the same rank pairs.
    localparam bit HAS_RN = (J < SQRT_N - 1);
    localparam bit HAS_RP = (J > 0);
    localparam int RN     = HAS_RN ? k + 1 : k;
    localparam int RP     = HAS_RP ? k - 1 : k;
    // Column neighbours sit in adjacent rows at the same grid column.
    localparam bit HAS_CN = (R < SQRT_N - 1);
    localparam bit HAS_CP = (R > 0);
    localparam int CN     = HAS_CN ? rank_of(R + 1, COL) : k;
    localparam int CP     = HAS_CP ? rank_of(R - 1, COL) : k;
    localparam bit J_ODD  = ((J % 2) == 1);
    localparam bit R_ODD  = ((R % 2) == 1);

    logic [W-1:0]          mine;
    logic [W-1:0]          other;
    logic                  has;
    logic                  lower;
    logic                  take;
    logic [ADDR_WIDTH-1:0] mine_addr;
    logic [ADDR_WIDTH-1:0] other_addr;

    always_comb begin
      mine  = pkt_q[k];
      other = pkt_q[k];
      has   = 1'b0;
      lower = 1'b0;
      if (!col_phase) begin
        // Pairs (j, j+1) start at j with the same parity as the step.
        if (J_ODD == par) begin
          has   = HAS_RN;
          lower = 1'b1;
          other = pkt_q[RN];
        end else begin
          has   = HAS_RP;
          other = pkt_q[RP];
        end
      end else begin
        if (R_ODD == par) begin
          has   = HAS_CN;
          lower = 1'b1;
          other = pkt_q[CN];
        end else begin
          has   = HAS_CP;
          other = pkt_q[CP];
        end
      end
    end

    assign mine_addr  = mine[W-1 -: ADDR_WIDTH];
    assign other_addr = other[W-1 -: ADDR_WIDTH];
    // Strict compares: equal addresses never swap.
    assign take = sort_en && has &&
                  (lower ? (other_addr < mine_addr) : (other_addr > mine_addr));

    assign pkt_d[k]        = take ? other : mine;
    assign init_pkt[k]     = {ADDR_WIDTH'(N - 1 - k), DATA_WIDTH'(k)};
    assign nanci_result[k] = {~done_q, pkt_q[k]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
      cyc_q  <= '0;
      done_q <= 1'b0;
      pkt_q  <= init_pkt;
    end else begin
      step_q <= step_d;
      cyc_q  <= cyc_d;
      done_q <= done_d;
      pkt_q  <= pkt_d;
    end
  end

endmodule

// File: tb/tb_mesh_db_sort.sv
// Purpose : bench for mesh_db_sort; three parameterisations run side by side off one clock/reset.
// Latency : checks every cycle against a grid-level shearsort model and the pending timing rule.
// Backpr. : not applicable; the design has no flow control.
module tb_mesh_db_sort;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [12:0] res_a [0:63];
  logic [12:0] res_b [0:63];
  logic [8:0]  res_c [0:15];

  mesh_db_sort dut_a (.clk(clk), .rst(rst), .nanci_result(res_a));

  mesh_db_sort #(.SORT_CYCLES(100)) dut_b (.clk(clk), .rst(rst), .nanci_result(res_b));

  mesh_db_sort #(.N(16), .SQRT_N(4), .ADDR_WIDTH(4), .DATA_WIDTH(4))
    dut_c (.clk(clk), .rst(rst), .nanci_result(res_c));

  // Model grid is row-major by physical (row, column); a packet is addr*1024 + data.
  typedef int grid_t [64];

  grid_t ga;
  grid_t gc;
  int    ncyc;
  bit    in_reset;
  int    n_chk;
  int    n_fail;

  function automatic grid_t load_grid(input int side);
    grid_t g;
    int n, r, c, col;
    n = side * side;
    for (int k = 0; k < 64; k++) g[k] = 0;
    for (int k = 0; k < n; k++) begin
      r   = k / side;
      c   = k % side;
      col = (r % 2 == 0) ? c : side - 1 - c;
      g[r * side + col] = (n - 1 - k) * 1024 + k;
    end
    return g;
  endfunction

  function automatic grid_t mstep(input grid_t g, input int side, input int tot, input int step);
    grid_t h;
    int p, s, a, b, lo, hi, tmp;
    h = g;
    if (step >= tot) return h;
    p = step / side;
    s = step % side;
    if (p % 2 == 0) begin
      for (int r = 0; r < side; r++)
        for (int c = s % 2; c + 1 < side; c += 2) begin
          a  = r * side + c;
          b  = a + 1;
          lo = (r % 2 == 0) ? a : b;   // odd rows ascend right to left
          hi = (r % 2 == 0) ? b : a;
          if (h[hi] / 1024 < h[lo] / 1024) begin
            tmp = h[hi]; h[hi] = h[lo]; h[lo] = tmp;
          end
        end
    end else begin
      for (int c = 0; c < side; c++)
        for (int r = s % 2; r + 1 < side; r += 2) begin
          a = r * side + c;
          b = (r + 1) * side + c;
          if (h[b] / 1024 < h[a] / 1024) begin
            tmp = h[b]; h[b] = h[a]; h[a] = tmp;
          end
        end
    end
    return h;
  endfunction

  function automatic int snake_val(input grid_t g, input int side, input int i);
    int r, c;
    r = i / side;
    c = i % side;
    return g[r * side + ((r % 2 == 0) ? c : side - 1 - c)];
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at cycle %0d: got %h, expected %h", nm, idx, ncyc, act, exp);
    end
  endtask

  task automatic check_all();
    int v;
    logic [12:0] e13;
    logic [8:0]  e9;
    logic pa, pb, pc;
    pa = in_reset || (ncyc < 56);
    pb = in_reset || (ncyc < 100);
    pc = in_reset || (ncyc < 53);
    for (int i = 0; i < 64; i++) begin
      v   = snake_val(ga, 8, i);
      e13 = {pa, 6'(v / 1024), 6'(v % 1024)};
      chk("cyc_a", i, 32'(res_a[i]), 32'(e13));
      e13 = {pb, 6'(v / 1024), 6'(v % 1024)};
      chk("cyc_b", i, 32'(res_b[i]), 32'(e13));
    end
    for (int i = 0; i < 16; i++) begin
      v  = snake_val(gc, 4, i);
      e9 = {pc, 4'(v / 1024), 4'(v % 1024)};
      chk("cyc_c", i, 32'(res_c[i]), 32'(e9));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ga       = load_grid(8);
      gc       = load_grid(4);
      ncyc     = 0;
      in_reset = 1'b1;
    end else begin
      ga       = mstep(ga, 8, 56, ncyc);
      gc       = mstep(gc, 4, 20, ncyc);
      ncyc     = ncyc + 1;
      in_reset = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic final_checks();
    logic [12:0] e13;
    logic [8:0]  e9;
    chk("lit_a0",  0,  32'(res_a[0]),  32'h003F);
    chk("lit_a63", 63, 32'(res_a[63]), 32'h0FC0);
    for (int i = 0; i < 64; i++) begin
      e13 = {1'b0, 6'(i), 6'(63 - i)};
      chk("fin_a", i, 32'(res_a[i]), 32'(e13));
      chk("fin_b", i, 32'(res_b[i]), 32'(e13));
    end
    for (int i = 0; i < 16; i++) begin
      e9 = {1'b0, 4'(i), 4'(15 - i)};
      chk("fin_c", i, 32'(res_c[i]), 32'(e9));
    end
  endtask

  logic [12:0] snap [0:63];

  initial begin
    logic [12:0] e13;
    n_chk    = 0;
    n_fail   = 0;
    ncyc     = 0;
    in_reset = 1'b1;
    rst      = 1'b1;
    tick();
    tick();
    chk("rst_load_a0", 0, 32'(res_a[0]), 32'h1FC0);
    chk("rst_load_c0", 0, 32'(res_c[0]), 32'h1F0);
    rst = 1'b0;

    repeat (10) tick();
    chk("pend_c10", 10, 32'(res_a[7][12]), 32'd1);

    while (ncyc < 55) tick();
    chk("pend_a55", 55, 32'(res_a[0][12]), 32'd1);
    tick();
    chk("pend_a56", 56, 32'(res_a[0][12]), 32'd0);
    for (int i = 0; i < 64; i++) snap[i] = res_a[i];
    chk("b_pend56", 56, 32'(res_b[3][12]), 32'd1);
    for (int i = 0; i < 64; i++) begin
      e13 = {1'b0, 6'(i), 6'(63 - i)};
      chk("b_sorted56", i, 32'(res_b[i][11:0]), 32'(e13[11:0]));
    end

    while (ncyc < 60) tick();
    chk("lit_c0",  0,  32'(res_c[0]),  32'h00F);
    chk("lit_c15", 15, 32'(res_c[15]), 32'h0F0);
    chk("lit_c6",  6,  32'(res_c[6]),  32'h069);

    while (ncyc < 99) tick();
    chk("pend_b99", 99, 32'(res_b[0][12]), 32'd1);
    tick();
    chk("pend_b100", 100, 32'(res_b[0][12]), 32'd0);

    while (ncyc < 300) tick();
    for (int i = 0; i < 64; i++) chk("stable_a", i, 32'(res_a[i]), 32'(snap[i]));
    final_checks();

    // Mid-sort reset: restart, abort at cycle 20, then run a full schedule again.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    while (ncyc < 20) tick();
    rst = 1'b1;
    tick();
    chk("mid_pend_a", 0, 32'(res_a[0][12]), 32'd1);
    chk("mid_reload", 0, 32'(res_a[0]),     32'h1FC0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_pend_run", 1, 32'(res_a[40][12]), 32'd1);
    while (ncyc < 300) tick();
    final_checks();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
